dtc_share_sched: RTL and testbench
==================================

Name: dtc_share_sched

Overview:
- Time-multiplexes one combinational decision-tree classifier core (12-bit feature vector in, 3-bit class out) between N_REQ independent sample sources.
- Round-robin arbitration, at most one sample in flight.
- Registers the feature vector to the core, waits a fixed settle latency, then returns the class tagged with the requester index.
- Sits between the sample producers and the shared dtc core instance.

Parameters:
N_REQ, 4, number of requesters (1..8)
FEAT_W, 12, feature vector width
CLS_W, 3, class code width
CORE_LAT, 1, extra settle cycles before the core output is sampled (0..7)
CNT_W, 16, width of the served-sample counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester sample valid
req_feat  in  N_REQ*FEAT_W  per-requester feature vectors; requester i occupies bits [i*FEAT_W +: FEAT_W]
req_ready  out  N_REQ  one-hot grant/accept
core_feat  out  FEAT_W  registered feature vector driven to the classifier core
core_start  out  1  one-cycle pulse when core_feat is loaded
core_class  in  CLS_W  classifier core result (combinational from core_feat)
rsp_valid  out  1  result valid
rsp_id  out  $clog2(N_REQ) (min 1)  index of the requester that owns the result
rsp_class  out  CLS_W  captured class
rsp_ready  in  1  result consumer ready
served_cnt  out  CNT_W  count of completed response handshakes; wraps
busy  out  1  high in WAIT or RESP

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - state=IDLE, rr_ptr=0.
  - Outputs: req_ready=0, core_feat=0, core_start=0, rsp_valid=0, rsp_id=0, rsp_class=0, served_cnt=0, busy=0.
  - An in-flight sample is discarded and no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE, arbitration:
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[winner]=1 combinationally; every other bit is 0.
  - If no req_valid bit is set: req_ready=0, state and rr_ptr unchanged.
- IDLE, accept (req_valid[w] & req_ready[w]) at edge T:
  - core_feat <= req_feat[w]; tag <= w; lat_cnt <= CORE_LAT.
  - core_start=1 for exactly the cycle after T.
  - rr_ptr <= (w+1) mod N_REQ; state -> WAIT.
- WAIT:
  - req_ready=0 (all bits).
  - lat_cnt decrements each cycle.
  - In the WAIT cycle with lat_cnt==0: rsp_class <= core_class, rsp_id <= tag, rsp_valid <= 1, state -> RESP.
  - Result: core_class is sampled at edge T+1+CORE_LAT; rsp_valid is first high in the cycle after that edge.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_id and rsp_class are held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0, served_cnt <= served_cnt+1 (wraps 2^CNT_W-1 -> 0), state -> IDLE.
- core_feat holds its value until the next accept; it is never cleared except by reset.
- Throughput: with rsp_ready tied high, one sample per CORE_LAT+3 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely. No new accept occurs, and requesters see req_ready=0.
- Requester side: may drop req_valid without a handshake; no sample is lost because nothing was accepted.
- Back-to-back: a rsp handshake and a new accept never occur in the same cycle. The earliest accept is the cycle after the handshake.
- N_REQ=1: always grants requester 0; rsp_id width is 1 and always 0.

Test Plan (N_REQ=4, CORE_LAT=2 unless stated):
- Single request, req 2 asserts with feat=12'hA5C, core model returns 3'b101 → req_ready=4'b0100 same cycle; core_feat=12'hA5C and core_start pulse in the next cycle; rsp_valid high 4 cycles after accept edge, rsp_id=2, rsp_class=3'b101; served_cnt=1 after handshake.
- Round robin, all four req_valid held high, rsp_ready=1 → grants in order 0,1,2,3,0; accepts spaced 5 cycles apart; rsp_id sequence 0,1,2,3,0.
- Backpressure, rsp_ready=0 for 10 cycles after rsp_valid → rsp_id and rsp_class stable, req_ready=0 throughout; core_class changed during hold does not alter rsp_class; one response after release.
- Skip idle requesters, rr_ptr=1, only req 3 and req 0 valid → req 3 granted first, then req 0.
- Reset mid-WAIT, rst_n low one cycle after accept → all outputs 0 immediately; no response; next grant goes to requester 0.
- CORE_LAT=0 and counter wrap, CNT_W=4, 17 transactions → rsp_valid 2 cycles after each accept edge; served_cnt reads 1 after transaction 17.

Source files
------------

// File: rtl/dtc_share_sched.sv
// Round-robin scheduler that time-multiplexes one combinational decision-tree
// classifier core between N_REQ sample sources, one sample in flight at a time.
module dtc_share_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned FEAT_W   = 12,
  parameter int unsigned CLS_W    = 3,
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*FEAT_W-1:0]   req_feat,
  output logic [N_REQ-1:0]          req_ready,
  output logic [FEAT_W-1:0]         core_feat,
  output logic                      core_start,
  input  logic [CLS_W-1:0]          core_class,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CLS_W-1:0]          rsp_class,
  input  logic                      rsp_ready,
  output logic [CNT_W-1:0]          served_cnt,
  output logic                      busy
);

  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_tag;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [FEAT_W-1:0]  r_core_feat;
  logic               r_core_start;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [CLS_W-1:0]   r_rsp_class;
  logic [CNT_W-1:0]   r_served_cnt;
  logic               r_busy;

  logic [ID_W-1:0]    w_scan_idx;
  logic [ID_W-1:0]    w_win_idx;
  logic               w_win_vld;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [FEAT_W-1:0]  w_win_feat;
  logic [N_REQ-1:0]   w_grant;
  logic               w_accept;
  logic               w_capture;
  logic               w_rsp_hs;

  // First valid requester scanning upward from the round-robin pointer
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_scan_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_scan_idx = ID_W'((32'(r_rr_ptr) + k) % N_REQ);
      if (!w_win_vld && req_valid[w_scan_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_win_feat = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == w_win_idx) begin
        w_win_feat = req_feat[k*FEAT_W +: FEAT_W];
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == ID_W'(N_REQ - 1)) ? '0 : w_win_idx + ID_W'(1);

  always_comb begin
    w_grant = '0;
    if (r_state == ST_IDLE && w_win_vld) begin
      w_grant[w_win_idx] = 1'b1;
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the accept / capture / handshake strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_tag        <= '0;
      r_lat_cnt    <= '0;
      r_core_feat  <= '0;
      r_core_start <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_class  <= '0;
      r_served_cnt <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_core_start <= w_accept;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_core_feat <= w_win_feat;
        r_tag       <= w_win_idx;
        r_lat_cnt   <= LAT_W'(CORE_LAT);
        r_rr_ptr    <= w_ptr_nxt;
      end else if (r_state == ST_WAIT && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
      // Result is frozen once captured; the core may change underneath it
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_tag;
        r_rsp_class <= core_class;
      end else if (w_rsp_hs) begin
        r_rsp_valid  <= 1'b0;
        r_served_cnt <= r_served_cnt + CNT_W'(1);
      end
    end
  end

  assign core_feat  = r_core_feat;
  assign core_start = r_core_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_class  = r_rsp_class;
  assign served_cnt = r_served_cnt;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dtc_share_sched.sv
// Directed bench for dtc_share_sched: one instance with CORE_LAT=2, one with
// CORE_LAT=0 and a 4-bit served counter; the core is modelled as feat[11:9]^mask.
module tb_dtc_share_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cls_mask;

  logic [3:0]  a_req_valid, a_req_ready;
  logic [47:0] a_req_feat;
  logic [11:0] a_core_feat;
  logic        a_core_start;
  logic [2:0]  a_core_class;
  logic        a_rsp_valid, a_rsp_ready, a_busy;
  logic [1:0]  a_rsp_id;
  logic [2:0]  a_rsp_class;
  logic [15:0] a_served;

  logic [3:0]  b_req_valid, b_req_ready;
  logic [47:0] b_req_feat;
  logic [11:0] b_core_feat;
  logic        b_core_start;
  logic [2:0]  b_core_class;
  logic        b_rsp_valid, b_rsp_ready, b_busy;
  logic [1:0]  b_rsp_id;
  logic [2:0]  b_rsp_class;
  logic [3:0]  b_served;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign a_core_class = a_core_feat[11:9] ^ cls_mask;
  assign b_core_class = b_core_feat[11:9] ^ cls_mask;

  dtc_share_sched #(.N_REQ(4), .FEAT_W(12), .CLS_W(3), .CORE_LAT(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_feat(a_req_feat),
    .req_ready(a_req_ready), .core_feat(a_core_feat), .core_start(a_core_start),
    .core_class(a_core_class), .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id),
    .rsp_class(a_rsp_class), .rsp_ready(a_rsp_ready), .served_cnt(a_served), .busy(a_busy)
  );

  dtc_share_sched #(.N_REQ(4), .FEAT_W(12), .CLS_W(3), .CORE_LAT(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_feat(b_req_feat),
    .req_ready(b_req_ready), .core_feat(b_core_feat), .core_start(b_core_start),
    .core_class(b_core_class), .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id),
    .rsp_class(b_rsp_class), .rsp_ready(b_rsp_ready), .served_cnt(b_served), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n       = 1'b0;
    a_req_valid = '0; a_req_feat = '0; a_rsp_ready = 1'b0;
    b_req_valid = '0; b_req_feat = '0; b_rsp_ready = 1'b0;
    cls_mask    = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Counts negedges after the accept edge until rsp_valid is seen (bounded)
  task automatic wait_rsp_a(input int start, output int lat);
    lat = start;
    while (!a_rsp_valid && lat < 20) begin
      cyc(); settle();
      lat++;
    end
  endtask

  task automatic chk_all_zero_a(input string tag);
    chk({tag, "_ready"},  32'(a_req_ready),  32'h0);
    chk({tag, "_feat"},   32'(a_core_feat),  32'h0);
    chk({tag, "_start"},  32'(a_core_start), 32'h0);
    chk({tag, "_rvalid"}, 32'(a_rsp_valid),  32'h0);
    chk({tag, "_rid"},    32'(a_rsp_id),     32'h0);
    chk({tag, "_rcls"},   32'(a_rsp_class),  32'h0);
    chk({tag, "_cnt"},    32'(a_served),     32'h0);
    chk({tag, "_busy"},   32'(a_busy),       32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, seen, idx;
    int g_idx[$], g_cyc[$], r_id[$], r_cls[$], r_cyc[$];
    logic prev;
    logic [2:0] hold_cls;

    rst_n = 1'b1;
    a_req_valid = '0; a_req_feat = '0; a_rsp_ready = 1'b0;
    b_req_valid = '0; b_req_feat = '0; b_rsp_ready = 1'b0;
    cls_mask = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero_a("rst_a");
    chk("rst_b_cnt", 32'(b_served), 32'h0);
    chk("rst_b_rvalid", 32'(b_rsp_valid), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    // single request from requester 2
    do_reset();
    a_rsp_ready = 1'b1;
    a_req_feat[24 +: 12] = 12'hA5C;
    a_req_valid = 4'b0100;
    settle();
    chk("t1_grant", 32'(a_req_ready), 32'h4);
    cyc(); settle();
    chk("t1_feat", 32'(a_core_feat), 32'hA5C);
    chk("t1_start", 32'(a_core_start), 32'h1);
    chk("t1_busy", 32'(a_busy), 32'h1);
    chk("t1_wait_ready", 32'(a_req_ready), 32'h0);
    a_req_valid = '0;
    cyc(); settle();
    chk("t1_start_pulse", 32'(a_core_start), 32'h0);
    wait_rsp_a(2, lat);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_id", 32'(a_rsp_id), 32'd2);
    chk("t1_cls", 32'(a_rsp_class), 32'h5);
    cyc(); settle();
    chk("t1_rvalid_off", 32'(a_rsp_valid), 32'h0);
    chk("t1_cnt", 32'(a_served), 32'd1);
    chk("t1_idle", 32'(a_busy), 32'h0);

    // round robin with all requesters valid
    do_reset();
    a_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) a_req_feat[i*12 +: 12] = {3'(i + 1), 9'(i * 37)};
    a_req_valid = 4'b1111;
    prev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      settle();
      if (a_req_ready != '0) begin
        idx = 0;
        for (int j = 0; j < 4; j++) if (a_req_ready[j]) idx = j;
        g_idx.push_back(idx);
        g_cyc.push_back(c);
      end
      if (a_rsp_valid && !prev) begin
        r_id.push_back(int'(a_rsp_id));
        r_cls.push_back(int'(a_rsp_class));
        r_cyc.push_back(c);
      end
      prev = a_rsp_valid;
      if (g_idx.size() >= 5 && c > g_cyc[4]) a_req_valid = '0;
      cyc();
    end
    chk("t2_ngrant", 32'(g_idx.size()), 32'd5);
    chk("t2_nrsp", 32'(r_id.size()), 32'd5);
    for (int k = 0; k < 5 && k < g_idx.size() && k < r_id.size(); k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(g_idx[k]), 32'(k % 4));
      chk($sformatf("t2_rid%0d", k), 32'(r_id[k]), 32'(k % 4));
      chk($sformatf("t2_rcls%0d", k), 32'(r_cls[k]), 32'((k % 4) + 1));
      chk($sformatf("t2_lat%0d", k), 32'(r_cyc[k] - g_cyc[k]), 32'd4);
      if (k > 0) chk($sformatf("t2_space%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd5);
    end
    chk("t2_cnt", 32'(a_served), 32'd5);

    // backpressure holds the response and blocks arbitration
    do_reset();
    a_rsp_ready = 1'b0;
    a_req_feat[12 +: 12] = 12'h3C7;
    a_req_valid = 4'b0010;
    settle();
    chk("t3_grant", 32'(a_req_ready), 32'h2);
    cyc();
    a_req_valid = 4'b1101;
    settle();
    chk("t3_wait_ready", 32'(a_req_ready), 32'h0);
    wait_rsp_a(1, lat);
    chk("t3_lat", 32'(lat), 32'd4);
    chk("t3_id", 32'(a_rsp_id), 32'd1);
    chk("t3_cls", 32'(a_rsp_class), 32'h1);
    cls_mask = 3'b110;
    for (int h = 0; h < 10; h++) begin
      cyc(); settle();
      chk($sformatf("t3_hold_valid%0d", h), 32'(a_rsp_valid), 32'h1);
      chk($sformatf("t3_hold_id%0d", h), 32'(a_rsp_id), 32'd1);
      chk($sformatf("t3_hold_cls%0d", h), 32'(a_rsp_class), 32'h1);
      chk($sformatf("t3_hold_ready%0d", h), 32'(a_req_ready), 32'h0);
    end
    a_rsp_ready = 1'b1;
    a_req_valid = '0;
    cls_mask = '0;
    cyc(); settle();
    chk("t3_release", 32'(a_rsp_valid), 32'h0);
    chk("t3_cnt", 32'(a_served), 32'd1);
    cyc(); cyc(); settle();
    chk("t3_cnt_once", 32'(a_served), 32'd1);
    chk("t3_idle", 32'(a_busy), 32'h0);

    // skip idle requesters starting from rr_ptr=1
    do_reset();
    a_rsp_ready = 1'b1;
    a_req_feat[0 +: 12] = 12'h200;
    a_req_valid = 4'b0001;
    settle();
    chk("t4_pre_grant", 32'(a_req_ready), 32'h1);
    cyc(); settle();
    a_req_valid = '0;
    wait_rsp_a(1, lat);
    cyc();
    a_req_feat[36 +: 12] = 12'hE00;
    a_req_feat[0 +: 12]  = 12'h400;
    a_req_valid = 4'b1001;
    settle();
    chk("t4_grant3", 32'(a_req_ready), 32'h8);
    cyc();
    a_req_valid = 4'b0001;
    settle();
    n = 0;
    hold_cls = '0;
    seen = -1;
    while (a_req_ready == '0 && n < 20) begin
      if (a_rsp_valid) begin
        seen = int'(a_rsp_id);
        hold_cls = a_rsp_class;
      end
      cyc(); settle();
      n++;
    end
    chk("t4_grant0", 32'(a_req_ready), 32'h1);
    chk("t4_rid3", 32'(seen), 32'd3);
    chk("t4_rcls3", 32'(hold_cls), 32'h7);
    cyc(); settle();
    a_req_valid = '0;
    wait_rsp_a(1, lat);
    chk("t4_rid0", 32'(a_rsp_id), 32'd0);
    chk("t4_rcls0", 32'(a_rsp_class), 32'h2);
    cyc();

    // reset in the middle of WAIT
    do_reset();
    a_rsp_ready = 1'b1;
    a_req_feat[24 +: 12] = 12'h8F1;
    a_req_valid = 4'b0100;
    settle();
    cyc(); settle();
    chk("t5_accepted", 32'(a_core_start), 32'h1);
    rst_n = 1'b0;
    a_req_valid = '0;
    settle();
    chk_all_zero_a("t5_rst");
    cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int h = 0; h < 8; h++) begin
      cyc(); settle();
      if (a_rsp_valid) seen++;
    end
    chk("t5_no_rsp", 32'(seen), 32'd0);
    a_req_valid = 4'b1111;
    settle();
    chk("t5_grant0", 32'(a_req_ready), 32'h1);
    a_req_valid = '0;

    // zero settle latency and counter wrap
    do_reset();
    b_rsp_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      idx = k % 4;
      b_req_feat[idx*12 +: 12] = {3'(k % 8), 9'(k)};
      b_req_valid = 4'(1 << idx);
      settle();
      chk($sformatf("t6_grant%0d", k), 32'(b_req_ready), 32'(1 << idx));
      cyc(); settle();
      b_req_valid = '0;
      lat = 1;
      while (!b_rsp_valid && lat < 20) begin
        cyc(); settle();
        lat++;
      end
      chk($sformatf("t6_lat%0d", k), 32'(lat), 32'd2);
      chk($sformatf("t6_rid%0d", k), 32'(b_rsp_id), 32'(idx));
      chk($sformatf("t6_rcls%0d", k), 32'(b_rsp_class), 32'(k % 8));
      cyc(); settle();
      chk($sformatf("t6_cnt%0d", k), 32'(b_served), 32'((k + 1) % 16));
    end
    chk("t6_cnt_final", 32'(b_served), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
